// File: rtl/ks_strummer.sv
// Strum sequencer: walks the strings in one direction, one slot every gap+1 sample periods,
// and issues a single-cycle pluck pulse for each string selected by the latched mask.
module ks_strummer #(
    parameter int NUM_STRINGS = 6
) (
    input  logic                   lrck,
    input  logic                   rst_n,
    input  logic                   strum_valid,
    output logic                   strum_ready,
    input  logic [NUM_STRINGS-1:0] strum_mask,
    input  logic                   strum_dir,
    input  logic [9:0]             strum_gap,
    input  logic                   abort,
    output logic [NUM_STRINGS-1:0] pluck,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = $clog2(NUM_STRINGS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STRINGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SLOT,
        GAP
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [9:0]             cnt_reg, cnt_next;
    logic [NUM_STRINGS-1:0] mask_reg, mask_next;
    logic                   dir_reg, dir_next;
    logic [9:0]             gap_reg, gap_next;
    logic                   done_reg, done_next;
    logic [NUM_STRINGS-1:0] pluck_reg, pluck_next;

    logic                   load_slot;
    logic                   advance;
    logic [IDX_W-1:0]       slot_idx;
    logic [NUM_STRINGS-1:0] slot_mask;
    logic [IDX_W-1:0]       step_idx;
    logic                   last_slot;

    assign step_idx  = dir_reg ? (idx_reg - 1'b1) : (idx_reg + 1'b1);
    assign last_slot = dir_reg ? (idx_reg == '0) : (idx_reg == IDX_LAST);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        mask_next  = mask_reg;
        dir_next   = dir_reg;
        gap_next   = gap_reg;
        done_next  = 1'b0;
        load_slot  = 1'b0;
        advance    = 1'b0;
        slot_idx   = idx_reg;
        slot_mask  = mask_reg;

        case (state_reg)
            IDLE: begin
                if (strum_valid && !abort) begin
                    mask_next  = strum_mask;
                    dir_next   = strum_dir;
                    gap_next   = strum_gap;
                    slot_idx   = strum_dir ? IDX_LAST : '0;
                    slot_mask  = strum_mask;
                    idx_next   = slot_idx;
                    load_slot  = 1'b1;
                    state_next = SLOT;
                end
            end
            SLOT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_reg == '0) begin
                    advance = 1'b1;
                end else begin
                    state_next = GAP;
                    cnt_next   = gap_reg - 10'd1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 10'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Leaving a slot (directly or after its gap): finish or move to the neighbouring string
        if (advance) begin
            if (last_slot) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end else begin
                state_next = SLOT;
                slot_idx   = step_idx;
                idx_next   = step_idx;
                load_slot  = 1'b1;
            end
        end
    end

    // One-hot decode keeps at most one pluck bit set per cycle
    generate
        for (genvar gi = 0; gi < NUM_STRINGS; gi++) begin : g_pluck
            assign pluck_next[gi] = load_slot & slot_mask[gi] & (slot_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge lrck or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            mask_reg  <= '0;
            dir_reg   <= 1'b0;
            gap_reg   <= '0;
            done_reg  <= 1'b0;
            pluck_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            mask_reg  <= mask_next;
            dir_reg   <= dir_next;
            gap_reg   <= gap_next;
            done_reg  <= done_next;
            pluck_reg <= pluck_next;
        end
    end

    assign strum_ready = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign pluck       = pluck_reg;
    assign done        = done_reg;

endmodule

// File: doc/ks_strummer.md
KS_STRUMMER -- requirements
Module: ks_strummer

Interface
REQ-001 SHALL have parameter NUM_STRINGS, default 6: number of strings sequenced, range 2..16.
REQ-002 SHALL have port lrck, input, 1 bit: the sole clock (one sample period per cycle); all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port strum_valid, input, 1 bit: a strum request is presented.
REQ-005 SHALL have port strum_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port strum_mask, input, NUM_STRINGS bits: strings to pluck, bit i selects string i.
REQ-007 SHALL have port strum_dir, input, 1 bit: 0 visits strings 0 up to NUM_STRINGS-1, 1 visits NUM_STRINGS-1 down to 0.
REQ-008 SHALL have port strum_gap, input, 10 bits unsigned: idle cycles between consecutive string slots.
REQ-009 SHALL have port abort, input, 1 bit: synchronous cancel of the strum in progress.
REQ-010 SHALL have port pluck, output, NUM_STRINGS bits: one-cycle pluck pulse per string, for the per-string pluck inputs.
REQ-011 SHALL have port busy, output, 1 bit: a strum is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a strum completes normally.

Function
REQ-013 SHALL implement an FSM with states IDLE, SLOT and GAP; all outputs SHALL be registered.
REQ-014 strum_ready SHALL be 1 exactly when the state is IDLE; busy SHALL always equal the inverse of strum_ready.
REQ-015 A request SHALL be accepted on an edge k where strum_valid=1, strum_ready=1 and abort=0; mask, dir and gap SHALL be latched at that edge, and later input changes SHALL have no effect until completion.
REQ-016 The first slot index SHALL be 0 when dir=0 and NUM_STRINGS-1 when dir=1; after each slot the index SHALL step by +1 (dir=0) or -1 (dir=1).
REQ-017 Slot s (s = 0..NUM_STRINGS-1) SHALL begin at edge k+1+s*(gap+1); in that cycle pluck[index] SHALL be 1 if mask[index]=1, and every other pluck bit SHALL be 0.
REQ-018 Each slot SHALL be followed by exactly gap cycles in GAP with pluck all zero; gap=0 SHALL skip GAP, giving consecutive slots on consecutive cycles.
REQ-019 Masked-out strings SHALL still consume their full slot of gap+1 cycles, so strum duration SHALL be NUM_STRINGS*(gap+1) cycles regardless of mask.
REQ-020 At most one pluck bit SHALL be 1 in any cycle.
REQ-021 After the last slot and its gap, at edge k+NUM_STRINGS*(gap+1)+1, the FSM SHALL return to IDLE with done=1 for exactly one cycle and strum_ready=1 in the same cycle.
REQ-022 A new request presented in the done cycle SHALL be accepted on that edge.
REQ-023 mask=0 SHALL be accepted and run its full duration with no pluck pulses, then assert done.
REQ-024 abort=1 while busy SHALL return the FSM to IDLE on the next edge with pluck=0 and no done pulse.
REQ-025 abort=1 in IDLE SHALL block acceptance even when strum_valid=1.
REQ-026 The gap counter SHALL be 10 bits; gap=1023 SHALL yield 1023 idle cycles with no wrap error.

Reset
REQ-027 While rst_n=0, regardless of lrck: state=IDLE, pluck=0, done=0, busy=0, strum_ready=1, and index, counter and latched registers SHALL be cleared.
REQ-028 Reset asserted mid-strum SHALL abandon the strum with no done pulse; after release the block SHALL accept on the first edge with strum_valid=1.

Verification
REQ-029 NUM_STRINGS=6, mask=6'b111111, dir=0, gap=2, accepted at edge 10 -> pluck[0..5] pulse at edges 11,14,17,20,23,26; done at edge 29; busy edges 11-28.
REQ-030 mask=6'b100101, dir=1, gap=0, accepted at edge 5 -> pluck[5] at 6, pluck[2] at 9, pluck[0] at 11; no pulses at 7,8,10; done at 12.
REQ-031 mask=0, gap=3 -> no pluck for 24 cycles, done 25 cycles after acceptance.
REQ-032 abort at the third slot of a gap=4 strum -> idle next edge, no further plucks, done never asserted; request held during abort accepted only after abort deasserts.
REQ-033 rst_n pulled low asynchronously mid-GAP -> outputs reach reset values without a clock edge; back-to-back request in the done cycle accepted with zero idle cycles.
